multicycle_cpu: RTL
===================

# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle 8-bit CPU. It accepts one instruction at a time over a valid/ready handshake and decodes it into a NUM_REGS-entry register file. It executes on an internal ALU with carry/zero flags, and loads from or stores to an internal 2^ADDR_BITS-word data memory. The whole register file is exposed as a flattened output bus for observation by the board/top level.

## Interface
- DATA_WIDTH, 8, register/ALU/memory word width (≥4)
- ADDR_BITS, 5, data-memory address width; depth = 2^ADDR_BITS
- REG_BITS, 2, register-index width; NUM_REGS = 2^REG_BITS
- INSTR_WIDTH, 20, instruction width; must satisfy INSTR_WIDTH ≥ 4+3·REG_BITS+DATA_WIDTH

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  INSTR_WIDTH  instruction word
- instr_valid  in  1  instruction present
- instr_ready  out  1  CPU can accept an instruction (FETCH state and rst low)
- done  out  1  one-cycle pulse, high during WB of every accepted instruction
- illegal  out  1  one-cycle pulse with done when opcode undefined
- zero_flag  out  1  registered zero flag
- carry_flag  out  1  registered carry/borrow flag
- regs_out  out  NUM_REGS·DATA_WIDTH  register i at bits [i·DATA_WIDTH +: DATA_WIDTH]

## Operation
- Encoding: opcode = instruction[INSTR_WIDTH-1 -: 4]; rd, rs, rt = next three REG_BITS fields below it, in that order; imm = instruction[DATA_WIDTH-1:0]; remaining bits ignored.
- Opcodes:
  - 0 ADD: rd=rs+rt
  - 1 SUB: rd=rs−rt
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 ADDI: rd=rs+imm
  - 6 LW: rd=mem[ea]
  - 7 SW: mem[ea]=rt
  - 8 LI: rd=imm
  - 9 MOV: rd=rs
  - 15 NOP
  - 10–14 illegal
- Effective address ea = (rs+imm) truncated to ADDR_BITS bits. The address wraps, with no fault.
- Arithmetic is modulo 2^DATA_WIDTH.
  - ADD/ADDI: carry = bit DATA_WIDTH of the full sum.
  - SUB: carry = borrow (1 iff rs<rt unsigned).
  - AND/OR/XOR: clear carry.
  - zero = (result==0).
- Flags are updated only by opcodes 0–5. LW, SW, LI, MOV, NOP and illegal leave the flags unchanged.
- Any register may be a destination, including R0. rd==rs==rt is legal and reads old values.
- Illegal opcodes behave as NOP and raise illegal with done.
- Register operands are latched in DECODE. The instruction word is latched at the handshake; later changes on instruction are ignored.
- FSM states: FETCH → DECODE → EXEC → {MEM if LW/SW} → WB → FETCH.
  - FETCH: instr_ready=1; leaves only when instr_valid=1.
  - EXEC: registers ALU result / ea.
  - MEM: synchronous memory read (LW) or write (SW, written at MEM→WB edge).
  - WB: register write (LW, ALU ops, LI, MOV) and flag update on the WB→FETCH edge.
- Reset (any state): FSM→FETCH, all registers 0, flags 0, done/illegal 0, in-flight instruction abandoned with no register, flag or memory write. Memory contents are not reset.

## Timing
- Handshake: transfer on a rising edge with instr_valid && instr_ready. instr_ready is low in every state except FETCH and while rst=1.
- Latency counts edges after the accept edge E0:
  - ALU/LI/MOV/NOP/illegal: done high in cycle after E2; result visible on regs_out after E3; instr_ready high again after E3 (4 cycles per instruction).
  - LW/SW: done high in cycle after E3; result/memory visible after E4; 5 cycles per instruction.
- Back-to-back: with instr_valid held high, the next instruction is accepted on the edge following the return to FETCH. Throughput is one instruction per 4 or 5 cycles.
- No forwarding is needed: each instruction retires before the next is accepted.
- All outputs are registered. Reset values: instr_ready 0 while rst=1, 1 in the first cycle after rst deasserts; done 0; illegal 0; flags 0; regs_out 0.

## Test plan
- Reset, then LI R1,0x7F; LI R2,0x01; ADD R3,R1,R2 → R3=0x80, carry=0, zero=0; each done pulse exactly 3 cycles after its accept edge.
- LI R1,0xFF; ADDI R1,R1,0x01 → R1=0x00, carry=1, zero=1. Then SUB R2,R0,R1 with R0=0 → R2=0x00, carry=0, zero=1. Then SUB with 0x05−0x07 → 0xFE, carry=1.
- LI R1,0x1E; LI R2,0xA5; SW mem[R1+0x03]=R2 (ea wraps to 0x01); LW R3,[R0+0x01] → R3=0xA5; LW/SW done 4 cycles after accept; flags unchanged.
- Opcode 0xB with instr_valid held high continuously → illegal and done pulse together, no register or flag change; next instruction accepted exactly 4 cycles after the first accept.
- Assert rst for one cycle during EXEC of ADD R1 and during MEM of SW → R1 stays 0, memory word unchanged, no done; instr_ready=1 in the cycle after rst falls.
- instr_valid low for 10 cycles in FETCH → no state change; instruction input toggled after accept → executed result matches the latched word.

Source files
------------

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle CPU with a valid/ready instruction port, a register file, an ALU and a data memory
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   instruction   instruction word, latched when instr_valid && instr_ready
//   instr_valid   an instruction is present on instruction
//   instr_ready   high in FETCH while rst is low
//   done          one-cycle pulse during WB of every accepted instruction
//   illegal       pulses together with done when the opcode is undefined
//   zero_flag     registered zero flag
//   carry_flag    registered carry/borrow flag
//   regs_out      register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
module multicycle_cpu #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int REG_BITS    = 2,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INSTR_WIDTH-1:0]                instruction,
    input  logic                                  instr_valid,
    output logic                                  instr_ready,
    output logic                                  done,
    output logic                                  illegal,
    output logic                                  zero_flag,
    output logic                                  carry_flag,
    output logic [(1<<REG_BITS)*DATA_WIDTH-1:0]   regs_out
);
    localparam int NUM_REGS = 1 << REG_BITS;
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;

    logic [2:0]             state, next_state;
    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]  a, b, mdr;
    logic [DATA_WIDTH:0]    alu, res;
    logic [ADDR_BITS-1:0]   ea, ea_r;
    logic [DATA_WIDTH-1:0]  mem [1<<ADDR_BITS];
    logic [3:0]             op;
    logic [REG_BITS-1:0]    rd, rs, rt;
    logic [DATA_WIDTH-1:0]  imm;
    logic                   is_mem, legal, writes_reg, sets_flags;
    // the gap between rt and imm carries no meaning; fold it away explicitly
    logic                   unused_ir;

    assign op         = ir[INSTR_WIDTH-1 -: 4];
    assign rd         = ir[INSTR_WIDTH-5 -: REG_BITS];
    assign rs         = ir[INSTR_WIDTH-5-REG_BITS -: REG_BITS];
    assign rt         = ir[INSTR_WIDTH-5-2*REG_BITS -: REG_BITS];
    assign imm        = ir[DATA_WIDTH-1:0];
    assign unused_ir  = ^ir;
    assign is_mem     = op == 4'd6 || op == 4'd7;
    assign legal      = op <= 4'd9 || op == 4'd15;
    assign writes_reg = op <= 4'd6 || op == 4'd8 || op == 4'd9;
    assign sets_flags = op <= 4'd5;
    assign instr_ready = state == FETCH && !rst;
    assign ea = ADDR_BITS'(a + imm);

    always_comb begin
        next_state = state == FETCH  ? (instr_valid ? DECODE : FETCH) :
                     state == DECODE ? EXEC :
                     state == EXEC   ? (is_mem ? MEM : WB) :
                     state == MEM    ? WB : FETCH;
        // bit DATA_WIDTH holds carry for ADD/ADDI and borrow for SUB
        alu = op == 4'd0 ? {1'b0, a} + {1'b0, b} :
              op == 4'd1 ? {1'b0, a} - {1'b0, b} :
              op == 4'd2 ? {1'b0, a & b} :
              op == 4'd3 ? {1'b0, a | b} :
              op == 4'd4 ? {1'b0, a ^ b} :
              op == 4'd5 ? {1'b0, a} + {1'b0, imm} :
              op == 4'd8 ? {1'b0, imm} : {1'b0, a};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            done       <= 1'b0;
            illegal    <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state   <= next_state;
            done    <= next_state == WB;
            illegal <= next_state == WB && !legal;
            if (state == FETCH && instr_valid) ir <= instruction;
            if (state == DECODE) begin
                a <= regs[rs];
                b <= regs[rt];
            end
            if (state == EXEC) begin
                res  <= alu;
                ea_r <= ea;
            end
            if (state == WB) begin
                if (writes_reg) regs[rd] <= op == 4'd6 ? mdr : res[DATA_WIDTH-1:0];
                if (sets_flags) begin
                    zero_flag  <= res[DATA_WIDTH-1:0] == '0;
                    carry_flag <= res[DATA_WIDTH];
                end
            end
        end
    end

    // memory contents survive reset; only the access itself is suppressed
    always_ff @(posedge clk) begin
        if (!rst && state == MEM) begin
            if (op == 4'd7) mem[ea_r] <= b;
            mdr <= mem[ea_r];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
endmodule
